// File: rtl/serial_adder_controller_if.sv
// rtl/serial_adder_controller_if.sv - host-side handshake and operand/result bundle for the serial adder
interface serial_adder_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, A_in, B_in,
        input  ready, busy, done, sum, carry_out
    );

    modport slave (
        input  start, A_in, B_in,
        output ready, busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_adder_controller.sv
// rtl/serial_adder_controller.sv - bit-serial adder reusing one full-adder cell over WIDTH cycles, LSB first
module serial_adder_controller #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic                       clock,
    input  logic                       reset_b,
    serial_adder_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-2:0] s_hi;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] s_next;
    logic             carry, carry_out_reg;
    logic [CW-1:0]    count;
    logic             fa_sum, fa_carry, last_bit;

    assign fa_sum   = a_reg[0] ^ b_reg[0] ^ carry;
    assign fa_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign last_bit = (count == CW'(WIDTH - 1));
    // Only the upper WIDTH-1 partial-sum bits are ever read back, so bit 0 is not stored.
    assign s_next   = {fa_sum, s_hi};

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = bus.start ? ADD : IDLE;
            ADD:     state_next = last_bit ? DONE : ADD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE:    bus.ready = 1'b1;
            ADD:     bus.busy  = 1'b1;
            DONE:    bus.done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            a_reg         <= '0;
            b_reg         <= '0;
            s_hi          <= '0;
            carry         <= 1'b0;
            count         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.A_in;
                        b_reg <= bus.B_in;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                ADD: begin
                    s_hi  <= s_next[WIDTH-1:1];
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    carry <= fa_carry;
                    count <= count + CW'(1);
                    // Result registers move only here so they stay stable across the next ADD phase.
                    if (last_bit) begin
                        sum_reg       <= s_next;
                        carry_out_reg <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.carry_out = carry_out_reg;
endmodule

// File: tb/tb_serial_adder_controller.sv
// tb/tb_serial_adder_controller.sv - directed scoreboard bench for 8-bit and exhaustive 3-bit serial adders
module tb_serial_adder_controller;
    logic clock = 1'b0;
    logic reset_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [8:0] q8[$];
    logic [3:0] q3[$];

    always #5 clock = ~clock;

    serial_adder_controller_if #(.WIDTH(8)) bus8 ();
    serial_adder_controller_if #(.WIDTH(3)) bus3 ();

    serial_adder_controller #(.WIDTH(8), .CW(6)) u_dut8 (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus8)
    );

    serial_adder_controller #(.WIDTH(3), .CW(2)) u_dut3 (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus8.ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus8.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus8.done), 32'd0);
        chk({tag, "_sum"}, 32'(bus8.sum), 32'd0);
        chk({tag, "_cout"}, 32'(bus8.carry_out), 32'd0);
    endtask

    task automatic pop_check8(input string tag);
        logic [8:0] e;
        chk({tag, "_queue"}, 32'(q8.size() > 0), 32'd1);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({tag, "_result"}, 32'({bus8.carry_out, bus8.sum}), 32'(e));
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit glitch, input string tag);
        int k;
        logic [8:0] prev;
        @(negedge clock);
        prev = {bus8.carry_out, bus8.sum};
        bus8.A_in = a;
        bus8.B_in = b;
        bus8.start = 1'b1;
        q8.push_back({1'b0, a} + {1'b0, b});
        @(posedge clock);
        @(negedge clock);
        bus8.start = 1'b0;
        bus8.A_in = ~a;
        bus8.B_in = ~b;
        chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
        k = 0;
        while (!bus8.done && k < 40) begin
            if (glitch && k == 2) bus8.start = 1'b1;
            if (glitch && k == 3) bus8.start = 1'b0;
            if (k == 4) chk({tag, "_hold"}, 32'({bus8.carry_out, bus8.sum}), 32'(prev));
            @(negedge clock);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd8);
        pop_check8(tag);
        @(negedge clock);
        chk({tag, "_done_width"}, 32'(bus8.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus8.ready), 32'd1);
        if (glitch) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                chk({tag, "_no_extra"}, 32'({bus8.busy, bus8.done}), 32'd0);
            end
        end
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b);
        int k;
        logic [3:0] e;
        @(negedge clock);
        bus3.A_in = a;
        bus3.B_in = b;
        bus3.start = 1'b1;
        q3.push_back({1'b0, a} + {1'b0, b});
        @(posedge clock);
        @(negedge clock);
        bus3.start = 1'b0;
        k = 0;
        while (!bus3.done && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("w3_latency", 32'(k), 32'd3);
        e = q3.pop_front();
        chk($sformatf("w3_%0d_%0d", a, b), 32'({bus3.carry_out, bus3.sum}), 32'(e));
    endtask

    initial begin
        int done_cnt;
        int done_at[2];
        bus8.start = 1'b0;
        bus8.A_in = '0;
        bus8.B_in = '0;
        bus3.start = 1'b0;
        bus3.A_in = '0;
        bus3.B_in = '0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("por");
        reset_b = 1'b1;

        op8(8'h5A, 8'hC3, 1'b0, "basic");
        op8(8'hFF, 8'h01, 1'b0, "wrap");
        op8(8'h00, 8'h00, 1'b0, "zero");
        op8(8'h37, 8'h4C, 1'b1, "glitch");

        // Async reset between edges must clear outputs without a clock.
        @(negedge clock);
        #2;
        reset_b = 1'b0;
        #1;
        chk_reset_outputs("async_idle");
        @(negedge clock);
        reset_b = 1'b1;

        // start held high: back-to-back ops, operands sampled only at each accept.
        @(negedge clock);
        bus8.A_in = 8'h10;
        bus8.B_in = 8'h20;
        bus8.start = 1'b1;
        q8.push_back(9'h030);
        @(posedge clock);
        @(negedge clock);
        bus8.A_in = 8'h80;
        bus8.B_in = 8'h90;
        q8.push_back(9'h110);
        done_cnt = 0;
        done_at[0] = -1;
        done_at[1] = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            if (k == 9) chk("b2b_ready_gap", 32'(bus8.ready), 32'd1);
            if (k == 10) begin
                bus8.A_in = 8'hFF;
                bus8.B_in = 8'hFF;
                bus8.start = 1'b0;
            end
            if (k == 14) chk("b2b_hold", 32'({bus8.carry_out, bus8.sum}), 32'h030);
            if (bus8.done) begin
                if (done_cnt < 2) done_at[done_cnt] = k;
                done_cnt++;
                pop_check8("b2b");
            end
        end
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        chk("b2b_done0_at", 32'(done_at[0]), 32'd8);
        chk("b2b_done1_at", 32'(done_at[1]), 32'd18);

        // Abort after the 3rd ADD edge.
        @(negedge clock);
        bus8.A_in = 8'h5A;
        bus8.B_in = 8'hC3;
        bus8.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus8.start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_b = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clock);
        reset_b = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (bus8.done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        op8(8'h5A, 8'hC3, 1'b0, "after_abort");

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                op3(3'(a), 3'(b));
            end
        end

        chk("q8_empty", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
